// File: rtl/line_doubler_pkg.sv
// Shared RGB333 video definitions for the 15 kHz -> 31 kHz line doubler.
package line_doubler_pkg;
  localparam int RGB_W = 9;
  localparam logic [RGB_W-1:0] BLACK = 9'h000;

  // Field slices of {r[2:0], g[2:0], b[2:0]}
  localparam int R_HI = 8;
  localparam int R_LO = 6;
  localparam int G_HI = 5;
  localparam int G_LO = 3;
  localparam int B_HI = 2;
  localparam int B_LO = 0;

  typedef logic [RGB_W-1:0] rgb333_t;
endpackage

// File: rtl/line_buffer.sv
// Two-bank line store: simple dual-port RAM with synchronous write and registered read.
module line_buffer
  import line_doubler_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [ADDR_W:0]  wr_addr,
  input  logic [RGB_W-1:0] wr_data,
  input  logic [ADDR_W:0]  rd_addr,
  output logic [RGB_W-1:0] rd_data
);
  // Bank select is the address MSB, so both banks share one block RAM.
  rgb333_t mem [2**(ADDR_W+1)];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/line_doubler.sv
// Scan doubler: captures one 15 kHz line per bank and replays the other bank twice at 31 kHz.
module line_doubler
  import line_doubler_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int HS_LEN = 32
) (
  input  logic             clk_peripheral,
  input  logic             reset_n,
  input  logic             ce_in,
  input  logic             ce_out,
  input  logic [RGB_W-1:0] video_15,
  input  logic             hsync_n_in,
  input  logic             vsync_n_in,
  output logic [RGB_W-1:0] video_31,
  output logic             hsync,
  output logic             vsync
);
  localparam int HS_W = $clog2(HS_LEN + 1);
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
  localparam logic [HS_W-1:0] HS_LAST = HS_W'(HS_LEN - 1);

  logic              hs_prev;
  logic              synced;
  logic              wr_bank;
  logic              pass;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] line_len;
  logic [HS_W-1:0]   hs_cnt;
  logic              line_start;
  logic              wr_en;
  logic              blank_p0;
  logic              blank_p1;
  rgb333_t           rd_data_p1;

  assign line_start = ce_in && !hsync_n_in && hs_prev;
  // Nothing is captured until the first line start, so the first line after reset is black.
  assign wr_en = ce_in && !line_start && synced && (wr_addr != ADDR_MAX);

  always_ff @(posedge clk_peripheral or negedge reset_n) begin
    if (!reset_n) begin
      hs_prev  <= 1'b1;
      synced   <= 1'b0;
      wr_bank  <= 1'b0;
      wr_addr  <= '0;
      line_len <= '0;
      vsync    <= 1'b1;
    end else if (ce_in) begin
      hs_prev <= hsync_n_in;
      if (line_start) begin
        synced   <= 1'b1;
        wr_bank  <= ~wr_bank;
        wr_addr  <= '0;
        line_len <= wr_addr;
        vsync    <= vsync_n_in;
      end else if (wr_en) begin
        wr_addr <= wr_addr + 1'b1;
      end
    end
  end

  // The read address only advances once the pass's hsync pulse has ended.
  always_ff @(posedge clk_peripheral or negedge reset_n) begin
    if (!reset_n) begin
      rd_addr <= '0;
      pass    <= 1'b0;
      hs_cnt  <= '0;
      hsync   <= 1'b1;
    end else if (line_start) begin
      rd_addr <= '0;
      pass    <= 1'b0;
      hs_cnt  <= '0;
      hsync   <= 1'b0;
    end else if (ce_out) begin
      if (!hsync) begin
        if (hs_cnt == HS_LAST) hsync <= 1'b1;
        else hs_cnt <= hs_cnt + 1'b1;
      end else if (rd_addr < line_len) begin
        if ((rd_addr == line_len - 1'b1) && !pass) begin
          rd_addr <= '0;
          pass    <= 1'b1;
          hs_cnt  <= '0;
          hsync   <= 1'b0;
        end else begin
          rd_addr <= rd_addr + 1'b1;
        end
      end
    end
  end

  line_buffer #(.ADDR_W(ADDR_W)) u_line_buffer (
    .clk     (clk_peripheral),
    .wr_en   (wr_en),
    .wr_addr ({wr_bank, wr_addr}),
    .wr_data (video_15),
    .rd_addr ({~wr_bank, rd_addr}),
    .rd_data (rd_data_p1)
  );

  // Stage p0: address presented; also covers line_len == 0 since rd_addr >= 0 always holds.
  assign blank_p0 = !hsync || (rd_addr >= line_len);

  // Stage p1 -> p2: RAM data and blanking arrive together, then the output register.
  always_ff @(posedge clk_peripheral or negedge reset_n) begin
    if (!reset_n) begin
      blank_p1 <= 1'b1;
      video_31 <= BLACK;
    end else begin
      blank_p1 <= blank_p0;
      video_31 <= blank_p1 ? BLACK : rd_data_p1;
    end
  end
endmodule

// File: tb/tb_line_doubler.sv
// Self-checking bench for line_doubler against a line/tick-based reference model.
module tb_line_doubler;
  localparam int H      = 32;
  localparam int MAXLEN = 1023;
  localparam int BIG    = 1 << 20;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       ce_in;
  logic       ce_out;
  logic [8:0] video_15;
  logic       hsync_n_in;
  logic       vsync_n_in;
  logic [8:0] video_31;
  logic       hsync;
  logic       vsync;

  always #5 clk = ~clk;

  line_doubler #(.ADDR_W(10), .HS_LEN(H)) dut (
    .clk_peripheral (clk),
    .reset_n        (reset_n),
    .ce_in          (ce_in),
    .ce_out         (ce_out),
    .video_15       (video_15),
    .hsync_n_in     (hsync_n_in),
    .vsync_n_in     (vsync_n_in),
    .video_31       (video_31),
    .hsync          (hsync),
    .vsync          (vsync)
  );

  int total = 0;
  int passes = 0;
  int fails = 0;

  // Reference model: captured line in progress, line being shown, and
  // the number of ce_out ticks since the last line start.
  logic [8:0] cur   [1024];
  logic [8:0] shown [1024];
  int         cur_len;
  int         len;
  int         n;
  logic       m_hs_prev;
  logic       m_synced;
  logic       m_vs;
  logic [8:0] p0;
  logic [8:0] p1;

  bit         collect;
  logic [8:0] last;
  logic [8:0] seen [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_hs_prev = 1'b1;
    m_synced  = 1'b0;
    m_vs      = 1'b1;
    cur_len   = 0;
    len       = 0;
    n         = BIG;
    p0        = '0;
    p1        = '0;
  endfunction

  function automatic void model_edge();
    logic ls;
    ls = 1'b0;
    if (ce_in) begin
      ls = !hsync_n_in && m_hs_prev;
      m_hs_prev = hsync_n_in;
      if (ls) begin
        for (int i = 0; i < cur_len; i++) shown[i] = cur[i];
        len      = cur_len;
        cur_len  = 0;
        m_synced = 1'b1;
        m_vs     = vsync_n_in;
        n        = 0;
      end else if (m_synced && cur_len < MAXLEN) begin
        cur[cur_len] = video_15;
        cur_len++;
      end
    end
    if (!ls && ce_out && n < BIG) n++;
  endfunction

  // Output line: [hsync H][pass 0: L px][hsync H][pass 1: L px][black]
  function automatic logic exp_hsync(input int t, input int l);
    if (t < H) return 1'b0;
    if (l > 0 && t >= H + l && t < 2 * H + l) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [8:0] exp_pix(input int t, input int l);
    if (l == 0 || t < H) return 9'h000;
    if (t < H + l) return shown[t - H];
    if (t < 2 * H + l) return 9'h000;
    if (t < 2 * H + 2 * l) return shown[t - 2 * H - l];
    return 9'h000;
  endfunction

  task automatic tick(input logic ci, input logic co);
    logic [8:0] vid_exp;
    ce_in  = ci;
    ce_out = co;
    @(posedge clk);
    vid_exp = p1;
    p1 = p0;
    if (!reset_n) begin
      model_reset();
      vid_exp = '0;
    end else begin
      model_edge();
    end
    p0 = exp_pix(n, len);
    #1;
    check("video_31", 32'(video_31), 32'(vid_exp));
    check("hsync", 32'(hsync), 32'(exp_hsync(n, len)));
    check("vsync", 32'(vsync), 32'(m_vs));
    if (collect) begin
      if (video_31 == 9'h000) last = '0;
      else if (video_31 != last) begin
        seen.push_back(video_31);
        last = video_31;
      end
    end
  endtask

  // One input pixel period: ce_out fires twice per ce_in. The sync
  // glitch between ce_in pulses must be ignored by the DUT.
  task automatic in_px(input logic [8:0] pix, input logic hs_n, input logic vs_n);
    video_15   = pix;
    hsync_n_in = hs_n;
    vsync_n_in = vs_n;
    tick(1'b1, 1'b1);
    hsync_n_in = ~hs_n;
    tick(1'b0, 1'b0);
    hsync_n_in = hs_n;
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
  endtask

  task automatic out_only(input int ticks);
    for (int i = 0; i < ticks; i++) begin
      tick(1'b0, 1'b1);
      tick(1'b0, 1'b0);
    end
  endtask

  task automatic start_collect();
    seen.delete();
    last    = '0;
    collect = 1'b1;
  endtask

  int   nlow;
  int   npx;
  logic vs_n;

  initial begin
    reset_n    = 1'b0;
    ce_in      = 1'b0;
    ce_out     = 1'b0;
    video_15   = '0;
    hsync_n_in = 1'b1;
    vsync_n_in = 1'b1;
    collect    = 1'b0;
    last       = '0;
    model_reset();
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1);
    reset_n = 1'b1;

    // First line after reset: black, one hsync pulse, vsync high
    for (int i = 0; i < 3; i++) in_px(9'($urandom), 1'b1, 1'b1);
    in_px(9'($urandom), 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) in_px(9'($urandom), 1'b1, 1'b1);

    // Eight-pixel line replayed twice
    in_px(9'h1ff, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) in_px(9'(i + 1), 1'b1, 1'b1);
    in_px(9'h000, 1'b0, 1'b1);
    start_collect();
    out_only(90);
    collect = 1'b0;
    check("dbl_count", 32'(seen.size()), 32'd16);
    for (int i = 0; i < 16; i++)
      if (i < seen.size()) check("dbl_px", 32'(seen[i]), 32'((i % 8) + 1));

    // Early line start truncates an 8-pixel line; read restarts on the new bank
    for (int i = 0; i < 8; i++) in_px(9'($urandom_range(1, 511)), 1'b1, 1'b1);
    in_px(9'h000, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) in_px(9'h011 + 9'(i), 1'b1, 1'b1);
    in_px(9'h000, 1'b0, 1'b1);
    start_collect();
    out_only(80);
    collect = 1'b0;
    check("trunc_count", 32'(seen.size()), 32'd8);
    for (int i = 0; i < 8; i++)
      if (i < seen.size()) check("trunc_px", 32'(seen[i]), 32'h011 + 32'(i % 4));

    // Random lines, including vsync asserted at two line starts
    for (int k = 0; k < 8; k++) begin
      vs_n = (k == 2 || k == 3) ? 1'b0 : 1'b1;
      nlow = int'($urandom_range(0, 2));
      npx  = int'($urandom_range(0, 40));
      in_px(9'($urandom), 1'b0, vs_n);
      for (int j = 0; j < nlow; j++) in_px(9'($urandom), 1'b0, vs_n);
      for (int j = 0; j < npx; j++) in_px(9'($urandom), 1'b1, vs_n);
      if ($urandom_range(0, 1) == 1) out_only(int'($urandom_range(0, 150)));
    end
    in_px(9'($urandom), 1'b1, 1'b1);

    // Overlong line: write address saturates, no wrap into address 0
    in_px(9'h000, 1'b0, 1'b1);
    for (int i = 0; i < 1100; i++) in_px(9'((i % 509) + 1), 1'b1, 1'b1);
    in_px(9'h000, 1'b0, 1'b1);
    start_collect();
    out_only(2 * (H + MAXLEN) + 10);
    collect = 1'b0;
    check("long_count", 32'(seen.size()), 32'(2 * MAXLEN));
    if (seen.size() > MAXLEN) begin
      check("long_last", 32'(seen[MAXLEN - 1]), 32'(((MAXLEN - 1) % 509) + 1));
      check("long_wrap", 32'(seen[MAXLEN]), 32'd1);
    end

    // Asynchronous reset in the middle of pass 0
    in_px(9'h000, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) in_px(9'($urandom_range(1, 511)), 1'b1, 1'b0);
    in_px(9'h000, 1'b0, 1'b0);
    out_only(H + 10);
    #2 reset_n = 1'b0;
    #1;
    check("rst_video", 32'(video_31), 32'h0);
    check("rst_hsync", 32'(hsync), 32'h1);
    check("rst_vsync", 32'(vsync), 32'h1);
    model_reset();
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) in_px(9'($urandom), 1'b1, 1'b1);
    in_px(9'h000, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) in_px(9'h100 + 9'(i), 1'b1, 1'b1);
    in_px(9'h000, 1'b0, 1'b1);
    start_collect();
    out_only(2 * (H + 20) + 10);
    collect = 1'b0;
    check("recap_count", 32'(seen.size()), 32'd40);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
